// File: rtl/wb_retire_buffer_pkg.sv
// Shared writeback definitions: result-select codes, load-size codes and widths.
// Used by wb_result_sel, wb_retire_buffer_if and wb_retire_buffer.
package wb_retire_buffer_pkg;

  localparam int unsigned PC_WIDTH   = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // Writeback result select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // Load access size
  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

endpackage

// File: rtl/wb_retire_buffer_if.sv
// Writeback request channel into the retire buffer.
// master: producer (drives request, samples in_ready); slave: retire buffer.
// Signals: in_valid/in_ready handshake, wb_res_mux, reg_write_enable, reg_dst,
// alu_res, mem_data, imm, next_pc, mem_size, mem_unsigned.
interface wb_retire_buffer_if
  import wb_retire_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            wb_res_mux;
  logic                  reg_write_enable;
  logic [REG_ADDR_W-1:0] reg_dst;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] imm;
  logic [PC_WIDTH-1:0]   next_pc;
  logic [1:0]            mem_size;
  logic                  mem_unsigned;

  modport master (
    output in_valid, wb_res_mux, reg_write_enable, reg_dst,
           alu_res, mem_data, imm, next_pc, mem_size, mem_unsigned,
    input  in_ready
  );

  modport slave (
    input  in_valid, wb_res_mux, reg_write_enable, reg_dst,
           alu_res, mem_data, imm, next_pc, mem_size, mem_unsigned,
    output in_ready
  );

endinterface

// File: rtl/wb_result_sel.sv
// Combinational writeback result select and load extension.
// Inputs: sel, alu_res, mem_data, imm, next_pc, mem_size, mem_unsigned.
// Output: result_c (selected, extended result).
// Macro WB_LOAD_EXT_EN enables byte/half load sign/zero extension; otherwise
// mem_data passes through untouched.
module wb_result_sel
  import wb_retire_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]            sel,
  input  logic [DATA_WIDTH-1:0] alu_res,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [PC_WIDTH-1:0]   next_pc,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  output logic [DATA_WIDTH-1:0] result_c
);

  logic [DATA_WIDTH-1:0] load_c;

`ifdef WB_LOAD_EXT_EN
  // Byte/half loads: fill upper bits with the sign bit unless unsigned
  always_comb begin
    load_c = mem_data;
    case (mem_size)
      MEM_SIZE_BYTE: load_c = {{(DATA_WIDTH-8){mem_data[7] & ~mem_unsigned}}, mem_data[7:0]};
      MEM_SIZE_HALF: load_c = {{(DATA_WIDTH-16){mem_data[15] & ~mem_unsigned}}, mem_data[15:0]};
      default:       load_c = mem_data;
    endcase
  end
`else
  logic unused_load_ctl;
  assign unused_load_ctl = ^{mem_size, mem_unsigned};
  assign load_c = mem_data;
`endif

  // Result mux
  always_comb begin
    result_c = alu_res;
    case (sel)
      WB_ALU:  result_c = alu_res;
      WB_MEM:  result_c = load_c;
      WB_PC:   result_c = DATA_WIDTH'(next_pc);
      default: result_c = imm;
    endcase
  end

endmodule

// File: rtl/wb_retire_buffer.sv
// Writeback retire buffer: queues register-file writes until the RF port grants.
// Ports: clk, rst_n (async, active-low); req (wb_retire_buffer_if.slave);
// rf_we/rf_addr/rf_data/rf_ready (RF write port, head of queue);
// fwd_addr/fwd_hit/fwd_data (bypass lookup, youngest match); count (occupancy).
// Macro WB_LOAD_EXT_EN: see wb_result_sel.
module wb_retire_buffer
  import wb_retire_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  wb_retire_buffer_if.slave            req,
  output logic                         rf_we,
  output logic [REG_ADDR_W-1:0]        rf_addr,
  output logic [DATA_WIDTH-1:0]        rf_data,
  input  logic                         rf_ready,
  input  logic [REG_ADDR_W-1:0]        fwd_addr,
  output logic                         fwd_hit,
  output logic [DATA_WIDTH-1:0]        fwd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [REG_ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] result_c;
  logic                  push_c;
  logic                  pop_c;

  wb_result_sel #(.DATA_WIDTH(DATA_WIDTH)) u_sel (
    .sel          (req.wb_res_mux),
    .alu_res      (req.alu_res),
    .mem_data     (req.mem_data),
    .imm          (req.imm),
    .next_pc      (req.next_pc),
    .mem_size     (req.mem_size),
    .mem_unsigned (req.mem_unsigned),
    .result_c     (result_c)
  );

  // Full blocks acceptance even when a pop happens on the same edge
  assign req.in_ready = (count_q != CNT_W'(DEPTH));
  assign rf_we        = (count_q != '0);
  assign count        = count_q;

  // Accepted requests without a real destination are consumed and dropped
  assign push_c = req.in_valid && req.in_ready && req.reg_write_enable && (req.reg_dst != '0);
  assign pop_c  = rf_we && rf_ready;

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; validity comes from count_q
  always_ff @(posedge clk) begin
    if (push_c) begin
      addr_mem_q[wr_ptr_q] <= req.reg_dst;
      data_mem_q[wr_ptr_q] <= result_c;
    end
  end

  // Head of queue, masked when empty
  always_comb begin
    rf_addr = '0;
    rf_data = '0;
    if (rf_we) begin
      rf_addr = addr_mem_q[rd_ptr_q];
      rf_data = data_mem_q[rd_ptr_q];
    end
  end

  // Bypass search oldest to youngest so the youngest match wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((CNT_W'(i) < count_q) && (fwd_addr != '0) &&
          (addr_mem_q[PTR_W'(rd_ptr_q + PTR_W'(i))] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem_q[PTR_W'(rd_ptr_q + PTR_W'(i))];
      end
    end
  end

endmodule

// File: tb/tb_wb_retire_buffer.sv
module tb_wb_retire_buffer;
  import wb_retire_buffer_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        rf_ready = 1'b0;
  logic [4:0]  fwd_addr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;
  entry_t model_q[$];

  wb_retire_buffer_if #(.DATA_WIDTH(DW)) req_if ();

  wb_retire_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_if),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .rf_ready (rf_ready),
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic v, input logic we, input logic [4:0] dst,
                         input logic [1:0] sel, input logic [31:0] a,
                         input logic [31:0] m, input logic [31:0] i,
                         input logic [31:0] p, input logic [1:0] sz, input logic u);
    req_if.in_valid         = v;
    req_if.reg_write_enable = we;
    req_if.reg_dst          = dst;
    req_if.wb_res_mux       = sel;
    req_if.alu_res          = a;
    req_if.mem_data         = m;
    req_if.imm              = i;
    req_if.next_pc          = p;
    req_if.mem_size         = sz;
    req_if.mem_unsigned     = u;
  endtask

  task automatic push_alu(input logic [4:0] dst, input logic [31:0] val);
    set_req(1'b1, 1'b1, dst, WB_ALU, val, 32'h0, 32'h0, 32'h0, MEM_SIZE_WORD, 1'b0);
  endtask

  task automatic idle_req();
    req_if.in_valid = 1'b0;
  endtask

  // Reference result from the architectural writeback rules
  function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [31:0] a,
                                             input logic [31:0] m, input logic [31:0] i,
                                             input logic [31:0] p, input logic [1:0] sz,
                                             input logic u);
    logic [31:0] ld;
    ld = m;
`ifdef WB_LOAD_EXT_EN
    if (sz == MEM_SIZE_BYTE) ld = u ? {24'h0, m[7:0]} : {{24{m[7]}}, m[7:0]};
    else if (sz == MEM_SIZE_HALF) ld = u ? {16'h0, m[15:0]} : {{16{m[15]}}, m[15:0]};
`endif
    case (sel)
      WB_ALU:  return a;
      WB_MEM:  return ld;
      WB_PC:   return p;
      default: return i;
    endcase
  endfunction

  task automatic test_reset();
    #2;
    total++; if (count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count); else pass_cnt++;
    total++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got=%b exp=0", rf_we); else pass_cnt++;
    total++; if (req_if.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", req_if.in_ready); else pass_cnt++;
    total++; if (fwd_hit !== 1'b0) $display("FAIL reset_fwd_hit got=%b exp=0", fwd_hit); else pass_cnt++;
    total++; if (rf_addr !== 5'd0 || rf_data !== 32'h0 || fwd_data !== 32'h0)
      $display("FAIL reset_outputs got=%0d/%h/%h exp=0/0/0", rf_addr, rf_data, fwd_data); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    rf_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push_alu(5'(k), 32'(k * 32'h11));
      tick();
    end
    push_alu(5'd5, 32'h55);
    total++; if (count !== 3'd4) $display("FAIL fill_count got=%0d exp=4", count); else pass_cnt++;
    total++; if (req_if.in_ready !== 1'b0) $display("FAIL fill_in_ready got=%b exp=0", req_if.in_ready); else pass_cnt++;
    tick();
    total++; if (count !== 3'd4) $display("FAIL fill_stall_count got=%0d exp=4", count); else pass_cnt++;
    total++; if (rf_addr !== 5'd1 || rf_data !== 32'h11)
      $display("FAIL fill_head got=%0d/%h exp=1/11", rf_addr, rf_data); else pass_cnt++;
  endtask

  task automatic test_drain();
    logic [4:0] ea [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    logic [31:0] ed [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    logic [2:0] ec [5] = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1};
    rf_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (rf_we !== 1'b1 || rf_addr !== ea[k] || rf_data !== ed[k] || count !== ec[k])
        $display("FAIL drain_%0d got=we%b %0d/%h cnt%0d exp=we1 %0d/%h cnt%0d",
                 k, rf_we, rf_addr, rf_data, count, ea[k], ed[k], ec[k]);
      else pass_cnt++;
      tick();
      if (k == 1) idle_req();
    end
    total++; if (count !== 3'd0 || rf_we !== 1'b0)
      $display("FAIL drain_empty got=cnt%0d we%b exp=cnt0 we0", count, rf_we); else pass_cnt++;
    rf_ready = 1'b0;
  endtask

  task automatic test_drop();
    rf_ready = 1'b1;
    push_alu(5'd0, 32'hABCD);
    tick();
    total++; if (count !== 3'd0 || rf_we !== 1'b0)
      $display("FAIL drop_dst0 got=cnt%0d we%b exp=cnt0 we0", count, rf_we); else pass_cnt++;
    set_req(1'b1, 1'b0, 5'd7, WB_ALU, 32'h1234, 0, 0, 0, MEM_SIZE_WORD, 1'b0);
    tick();
    total++; if (count !== 3'd0 || rf_we !== 1'b0)
      $display("FAIL drop_we0 got=cnt%0d we%b exp=cnt0 we0", count, rf_we); else pass_cnt++;
    idle_req();
    rf_ready = 1'b0;
  endtask

  task automatic test_forward();
    rf_ready = 1'b0;
    push_alu(5'd5, 32'hA); tick();
    push_alu(5'd5, 32'hB); tick();
    push_alu(5'd6, 32'hC); tick();
    idle_req();
    fwd_addr = 5'd5; #1;
    total++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB)
      $display("FAIL fwd_r5 got=%b/%h exp=1/b", fwd_hit, fwd_data); else pass_cnt++;
    fwd_addr = 5'd0; #1;
    total++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0)
      $display("FAIL fwd_r0 got=%b/%h exp=0/0", fwd_hit, fwd_data); else pass_cnt++;
    fwd_addr = 5'd6; #1;
    total++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hC)
      $display("FAIL fwd_r6 got=%b/%h exp=1/c", fwd_hit, fwd_data); else pass_cnt++;
    fwd_addr = 5'd9; #1;
    total++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0)
      $display("FAIL fwd_miss got=%b/%h exp=0/0", fwd_hit, fwd_data); else pass_cnt++;
    rf_ready = 1'b1;
    tick(); tick(); tick();
    total++; if (count !== 3'd0) $display("FAIL fwd_drain got=%0d exp=0", count); else pass_cnt++;
    rf_ready = 1'b0;
    fwd_addr = 5'd0;
  endtask

  task automatic test_load_ext();
    logic [1:0]  sel [6] = '{WB_MEM, WB_MEM, WB_MEM, WB_MEM, WB_PC, WB_IMM};
    logic [31:0] mem [6] = '{32'h000000F0, 32'h000000F0, 32'h00008001, 32'h12345678, 32'h0, 32'h0};
    logic [1:0]  sz  [6] = '{MEM_SIZE_BYTE, MEM_SIZE_BYTE, MEM_SIZE_HALF, MEM_SIZE_WORD, MEM_SIZE_WORD, MEM_SIZE_WORD};
    logic        un  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef WB_LOAD_EXT_EN
    logic [31:0] ex  [6] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001, 32'h12345678, 32'h00001000, 32'hDEADBEEF};
`else
    logic [31:0] ex  [6] = '{32'h000000F0, 32'h000000F0, 32'h00008001, 32'h12345678, 32'h00001000, 32'hDEADBEEF};
`endif
    rf_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_req(1'b1, 1'b1, 5'd3, sel[k], 32'h77777777, mem[k], 32'hDEADBEEF, 32'h00001000, sz[k], un[k]);
      tick();
      idle_req();
      total++;
      if (rf_we !== 1'b1 || rf_addr !== 5'd3 || rf_data !== ex[k])
        $display("FAIL load_ext_%0d got=we%b %0d/%h exp=we1 3/%h", k, rf_we, rf_addr, rf_data, ex[k]);
      else pass_cnt++;
      tick();
    end
    rf_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    rf_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push_alu(5'(k + 10), 32'(k));
      tick();
    end
    idle_req();
    rf_ready = 1'b1;
    tick();
    total++; if (count !== 3'd3) $display("FAIL mid_pre_count got=%0d exp=3", count); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (count !== 3'd0 || rf_we !== 1'b0)
      $display("FAIL mid_reset got=cnt%0d we%b exp=cnt0 we0", count, rf_we); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (rf_we !== 1'b0 || count !== 3'd0)
        $display("FAIL mid_stale_%0d got=cnt%0d we%b exp=cnt0 we0", k, count, rf_we); else pass_cnt++;
    end
    rf_ready = 1'b0;
    model_q.delete();
  endtask

  task automatic test_random();
    logic        v, we, u, acc, pop;
    logic [4:0]  dst;
    logic [1:0]  sel, sz;
    logic [31:0] a, m, i, p, res;
    logic        e_hit;
    logic [31:0] e_fwd;
    for (int c = 0; c < 400; c++) begin
      // Compare the visible state with the model
      fwd_addr = 5'($urandom_range(0, 7));
      #1;
      e_hit = 1'b0; e_fwd = 32'h0;
      if (fwd_addr != 0)
        for (int k = model_q.size() - 1; k >= 0; k--)
          if (model_q[k].addr == fwd_addr) begin e_hit = 1'b1; e_fwd = model_q[k].data; break; end
      total++;
      if (count !== 3'(model_q.size()) || req_if.in_ready !== (model_q.size() != DEPTH) ||
          rf_we !== (model_q.size() != 0))
        $display("FAIL rand_state_%0d got=cnt%0d rdy%b we%b exp=cnt%0d", c, count, req_if.in_ready, rf_we, model_q.size());
      else pass_cnt++;
      total++;
      if (model_q.size() != 0) begin
        if (rf_addr !== model_q[0].addr || rf_data !== model_q[0].data)
          $display("FAIL rand_head_%0d got=%0d/%h exp=%0d/%h", c, rf_addr, rf_data, model_q[0].addr, model_q[0].data);
        else pass_cnt++;
      end else begin
        if (rf_addr !== 5'd0 || rf_data !== 32'h0)
          $display("FAIL rand_head_%0d got=%0d/%h exp=0/0", c, rf_addr, rf_data);
        else pass_cnt++;
      end
      total++;
      if (fwd_hit !== e_hit || fwd_data !== e_fwd)
        $display("FAIL rand_fwd_%0d addr=%0d got=%b/%h exp=%b/%h", c, fwd_addr, fwd_hit, fwd_data, e_hit, e_fwd);
      else pass_cnt++;
      // New stimulus
      v   = ($urandom_range(0, 9) < 7);
      we  = ($urandom_range(0, 9) < 8);
      dst = 5'($urandom_range(0, 7));
      sel = 2'($urandom_range(0, 3));
      sz  = 2'($urandom_range(0, 2));
      u   = 1'($urandom_range(0, 1));
      a = $urandom; m = $urandom; i = $urandom; p = $urandom;
      set_req(v, we, dst, sel, a, m, i, p, sz, u);
      rf_ready = ($urandom_range(0, 9) < 5);
      acc = v && (model_q.size() != DEPTH);
      pop = rf_ready && (model_q.size() != 0);
      res = ref_result(sel, a, m, i, p, sz, u);
      @(posedge clk);
      if (pop) void'(model_q.pop_front());
      if (acc && we && dst != 0) model_q.push_back('{dst, res});
      @(negedge clk);
    end
    idle_req();
    rf_ready = 1'b0;
  endtask

  initial begin
    set_req(1'b0, 1'b0, 5'd0, WB_ALU, 0, 0, 0, 0, MEM_SIZE_WORD, 1'b0);
    test_reset();
    test_fill();
    test_drain();
    test_drop();
    test_forward();
    test_load_ext();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
